// File: rtl/io_feeder.sv
// Host command FIFO feeding the CPU io port: issue with a one-cycle interrupt, wait HOLD cycles, capture io_dout.
// Optional response path (RESP state, rsp_data register) is enabled by defining IO_FEEDER_RESP_EN.
`ifndef BIT_INST
`define BIT_INST 16
`endif
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

module io_feeder #(
   parameter int BIT_INST = `BIT_INST,
   parameter int BIT_DATA = `BIT_DATA,
   parameter int DEPTH    = 8,
   parameter int SZB      = 3,
   parameter int HOLD     = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [BIT_INST-1:0] cmd_inst,
   input  logic [BIT_DATA-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [BIT_DATA-1:0] rsp_data,
   output logic                interrupt,
   output logic [BIT_INST-1:0] io_inst,
   output logic [BIT_DATA-1:0] io_din,
   input  logic [BIT_DATA-1:0] io_dout
);

   localparam logic [SZB:0] FULL_CNT = (SZB+1)'(DEPTH);
   localparam logic [7:0]   HOLD_M1  = 8'(HOLD-1);

`ifdef IO_FEEDER_RESP_EN
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
`endif

   state_t state_q, state_d;
   logic [SZB-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SZB:0]   count_q, count_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           irq_q, irq_d;
   logic [BIT_INST-1:0] inst_q, inst_d;
   logic [BIT_DATA-1:0] din_q, din_d;
   logic           push, pop, empty;
   logic [BIT_INST+BIT_DATA-1:0] mem [DEPTH];
   logic [BIT_INST+BIT_DATA-1:0] head;

   assign empty     = (count_q == '0);
   assign cmd_ready = (count_q != FULL_CNT);
   assign push      = cmd_valid & cmd_ready;
   assign head      = mem[rd_ptr_q];

   assign interrupt = irq_q;
   assign io_inst   = inst_q;
   assign io_din    = din_q;

`ifdef IO_FEEDER_RESP_EN
   logic                rv_q, rv_d;
   logic [BIT_DATA-1:0] rdat_q, rdat_d;
   assign rsp_valid = rv_q;
   assign rsp_data  = rdat_q;
`else
   logic unused_inputs;
   assign unused_inputs = ^{rsp_ready, io_dout};
   assign rsp_valid = 1'b0;
   assign rsp_data  = '0;
`endif

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_q] <= {cmd_inst, cmd_data};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      irq_d   = irq_q;
      inst_d  = inst_q;
      din_d   = din_q;
      pop     = 1'b0;
`ifdef IO_FEEDER_RESP_EN
      rv_d    = rv_q;
      rdat_d  = rdat_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_ISSUE;
               irq_d   = 1'b1;
               inst_d  = head[BIT_INST+BIT_DATA-1:BIT_DATA];
               din_d   = head[BIT_DATA-1:0];
               pop     = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            irq_d   = 1'b0;
            cnt_d   = HOLD_M1;
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
`ifdef IO_FEEDER_RESP_EN
               rv_d    = 1'b1;
               rdat_d  = io_dout;
               state_d = S_RESP;
`else
               state_d = S_IDLE;
`endif
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
`ifdef IO_FEEDER_RESP_EN
         S_RESP: begin
            if (rsp_ready) begin
               rv_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + SZB'(push);
      rd_ptr_d = rd_ptr_q + SZB'(pop);
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
         inst_q   <= '0;
         din_q    <= '0;
`ifdef IO_FEEDER_RESP_EN
         rv_q     <= 1'b0;
         rdat_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
         irq_q    <= irq_d;
         inst_q   <= inst_d;
         din_q    <= din_d;
`ifdef IO_FEEDER_RESP_EN
         rv_q     <= rv_d;
         rdat_q   <= rdat_d;
`endif
      end
   end

endmodule

// File: tb/tb_io_feeder.sv
// Directed self-checking bench for io_feeder (HOLD=4, DEPTH=8, 16-bit inst, 8-bit data).
module tb_io_feeder;

`ifdef IO_FEEDER_RESP_EN
   localparam bit RESP = 1'b1;
`else
   localparam bit RESP = 1'b0;
`endif
   localparam int SPACING = RESP ? 7 : 6;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_inst = '0;
   logic [7:0]  cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic        interrupt;
   logic [15:0] io_inst;
   logic [7:0]  io_din;
   logic [7:0]  io_dout;
   logic        use_f = 1'b0;
   logic [7:0]  dout_fix = '0;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int rv_cnt = 0;
   int          irq_t[$];
   logic [15:0] irq_i[$];
   logic [7:0]  irq_d[$];
   logic [7:0]  rsp_q[$];

   function automatic logic [7:0] f_dout(input logic [15:0] inst);
      return inst[7:0] ^ 8'hA5;
   endfunction

   assign io_dout = use_f ? f_dout(io_inst) : dout_fix;

   io_feeder #(.BIT_INST(16), .BIT_DATA(8), .DEPTH(8), .SZB(3), .HOLD(4)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .interrupt(interrupt), .io_inst(io_inst), .io_din(io_din), .io_dout(io_dout)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (interrupt) begin
         irq_t.push_back(cyc);
         irq_i.push_back(io_inst);
         irq_d.push_back(io_din);
      end
      if (rsp_valid) rv_cnt++;
      if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_mon();
      irq_t.delete(); irq_i.delete(); irq_d.delete(); rsp_q.delete();
      rv_cnt = 0;
   endtask

   task automatic push(input logic [15:0] inst, input logic [7:0] data);
      int k;
      cmd_valid = 1'b1; cmd_inst = inst; cmd_data = data;
      k = 0;
      while (!cmd_ready && k < 200) begin tick(); k++; end
      chk("push_wait", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      reset = 1'b0; tick(); reset = 1'b1; tick();
      clear_mon();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset behaviour
      tick(); tick(); tick();
      chk("rst_irq", {31'd0, interrupt}, 32'd0);
      chk("rst_inst", {16'd0, io_inst}, 32'd0);
      chk("rst_din", {24'd0, io_din}, 32'd0);
      chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdat", {24'd0, rsp_data}, 32'd0);
      chk("rst_rdy", {31'd0, cmd_ready}, 32'd1);
      reset = 1'b1;
      tick(); tick(); tick();
      chk("post_irq", {31'd0, interrupt}, 32'd0);
      chk("post_inst", {16'd0, io_inst}, 32'd0);
      chk("post_rv", {31'd0, rsp_valid}, 32'd0);
      chk("post_rdy", {31'd0, cmd_ready}, 32'd1);

      // single command
      clear_mon();
      dout_fix = 8'hC3;
      cmd_valid = 1'b1; cmd_inst = 16'h1234; cmd_data = 8'h5A;
      tick();
      cmd_valid = 1'b0;
      chk("t2_irq_e0", {31'd0, interrupt}, 32'd0);
      tick();
      chk("t2_irq_e1", {31'd0, interrupt}, 32'd1);
      chk("t2_inst_e1", {16'd0, io_inst}, 32'h1234);
      chk("t2_din_e1", {24'd0, io_din}, 32'h5A);
      tick();
      chk("t2_irq_e2", {31'd0, interrupt}, 32'd0);
      chk("t2_inst_e2", {16'd0, io_inst}, 32'h1234);
      tick(); tick(); tick();
      chk("t2_rv_e5", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("t2_rv_e6", {31'd0, rsp_valid}, {31'd0, RESP});
      chk("t2_rdat_e6", {24'd0, rsp_data}, RESP ? 32'hC3 : 32'h0);
      chk("t2_irq_cnt", irq_t.size(), 32'd1);

`ifdef IO_FEEDER_RESP_EN
      // fill the FIFO while the previous response is still pending
      use_f = 1'b1;
      for (int i = 0; i < 8; i++) push(16'h0300 + 16'(i), 8'(i));
      chk("t3_full", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b1; cmd_inst = 16'h0399; cmd_data = 8'h99;
      tick(); tick();
      cmd_valid = 1'b0;
      chk("t3_full_hold", {31'd0, cmd_ready}, 32'd0);
      chk("t3_no_issue", {31'd0, interrupt}, 32'd0);
      chk("t3_rdat_hold", {24'd0, rsp_data}, 32'hC3);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t3_rv_clr", {31'd0, rsp_valid}, 32'd0);
      clear_mon();
      tick();
      chk("t3_irq", {31'd0, interrupt}, 32'd1);
      chk("t3_inst", {16'd0, io_inst}, 32'h0300);
      chk("t3_rdy_back", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("t3_rv", {31'd0, rsp_valid}, 32'd1);
      chk("t3_rdat", {24'd0, rsp_data}, {24'd0, f_dout(16'h0300)});
      for (int i = 0; i < 10; i++) tick();
      chk("t3_rv_hold", {31'd0, rsp_valid}, 32'd1);
      chk("t3_one_issue", irq_t.size(), 32'd1);
`endif

      // ordering and wrap-around
      reset_pulse();
      use_f = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) push(16'h4000 + 16'(i), 8'(i * 3));
      begin
         int k = 0;
         while ((irq_t.size() < 20 || (RESP && rsp_q.size() < 20)) && k < 600) begin
            tick(); k++;
         end
      end
      tick(); tick();
      chk("t4_irq_n", irq_t.size(), 32'd20);
      chk("t4_rsp_n", rsp_q.size(), RESP ? 32'd20 : 32'd0);
      for (int i = 0; i < 20 && i < irq_t.size(); i++) begin
         chk($sformatf("t4_inst%0d", i), {16'd0, irq_i[i]}, 32'h4000 + i);
         chk($sformatf("t4_din%0d", i), {24'd0, irq_d[i]}, 32'(8'(i * 3)));
         if (i > 0) chk($sformatf("t4_gap%0d", i), irq_t[i] - irq_t[i-1], SPACING);
      end
      for (int i = 0; i < 20 && i < rsp_q.size(); i++)
         chk($sformatf("t4_rsp%0d", i), {24'd0, rsp_q[i]}, {24'd0, f_dout(16'h4000 + 16'(i))});
      if (!RESP) chk("t4_no_rv", rv_cnt, 32'd0);

      // reset in the middle of a WAIT with commands queued
      rsp_ready = 1'b0;
      clear_mon();
      for (int i = 0; i < 4; i++) push(16'h5000 + 16'(i), 8'(i));
      chk("t5_issued", irq_t.size(), 32'd1);
      reset = 1'b0;
      #1;
      chk("t5_rst_irq", {31'd0, interrupt}, 32'd0);
      chk("t5_rst_inst", {16'd0, io_inst}, 32'd0);
      chk("t5_rst_rdy", {31'd0, cmd_ready}, 32'd1);
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("t5_no_rv", rv_cnt, 32'd0);
      chk("t5_no_irq", irq_t.size(), 32'd1);
      chk("t5_rdy", {31'd0, cmd_ready}, 32'd1);
      clear_mon();
      push(16'h5A5A, 8'h11);
      tick(); tick();
      chk("t5_new_irq", irq_t.size(), 32'd1);
      if (irq_i.size() > 0) chk("t5_new_inst", {16'd0, irq_i[0]}, 32'h5A5A);

`ifndef IO_FEEDER_RESP_EN
      // two commands without the response path
      reset_pulse();
      push(16'h6001, 8'h01);
      push(16'h6002, 8'h02);
      for (int i = 0; i < 20; i++) tick();
      chk("t6_irq_n", irq_t.size(), 32'd2);
      if (irq_t.size() == 2) chk("t6_gap", irq_t[1] - irq_t[0], 32'd6);
      chk("t6_no_rv", rv_cnt, 32'd0);
      chk("t6_rdat", {24'd0, rsp_data}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/io_feeder.md
# io_feeder

Upstream front-end for `top`: it buffers host commands (instruction plus operand) in a small FIFO and presents them to the CPU's `io_inst`/`io_din` inputs. It signals each one with a single-cycle `interrupt` pulse, then waits a fixed service window and captures the CPU's `io_dout` as a response word for the host. Only one command is outstanding at the CPU at a time, so responses return in command order.

## Interface

Parameters:
- `BIT_INST`, default `` `BIT_INST ``: instruction width.
- `BIT_DATA`, default `` `BIT_DATA ``: data width.
- `DEPTH`, default 8: command FIFO entries; must be a power of 2, ≥ 2.
- `SZB`, default 3: log2(`DEPTH`).
- `HOLD`, default 4: CPU service cycles between the end of the interrupt pulse and `io_dout` capture; range 1..255.

Ports:
- `clock`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_inst`  in  `BIT_INST`  host instruction.
- `cmd_data`  in  `BIT_DATA`  host operand.
- `rsp_valid`  out  1  response word valid.
- `rsp_ready`  in  1  host accepts response.
- `rsp_data`  out  `BIT_DATA`  captured `io_dout`.
- `interrupt`  out  1  to `top.interrupt`.
- `io_inst`  out  `BIT_INST`  to `top.io_inst`.
- `io_din`  out  `BIT_DATA`  to `top.io_din`.
- `io_dout`  in  `BIT_DATA`  from `top.io_dout`.

## Operation

- FIFO storage:
  - Storage is `DEPTH` × (`BIT_INST`+`BIT_DATA`).
  - Read and write pointers are `SZB` bits and wrap modulo `DEPTH`.
  - The occupancy count is `SZB`+1 bits.
- Push and pop:
  - A push occurs when `cmd_valid & cmd_ready`.
  - `cmd_ready` = !full (combinational from the count).
  - A pop occurs only on the IDLE→ISSUE transition.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full is impossible, because `cmd_ready` is low.
- FSM states are IDLE, ISSUE, WAIT and RESP.
  - **IDLE**: if the FIFO is not empty, go to ISSUE. On that edge: load `io_inst`/`io_din` from the FIFO head, set `interrupt` to 1, pop.
  - **ISSUE**: lasts one cycle. Next edge: go to WAIT, set `interrupt` to 0, load the counter with `HOLD`-1.
  - **WAIT**: the counter decrements each cycle. At the edge where the counter is 0: set `rsp_data` to `io_dout`, set `rsp_valid` to 1, go to RESP.
  - **RESP**: on `rsp_ready`, clear `rsp_valid` and go to IDLE. No new issue happens while in RESP.
- `io_inst`/`io_din` hold their value from ISSUE until the next ISSUE, including through IDLE.
- All outputs are registered except `cmd_ready`.
- Reset values: `interrupt`=0, `io_inst`=0, `io_din`=0, `rsp_valid`=0, `rsp_data`=0, state=IDLE, pointers=0, count=0.
  - `cmd_ready` is therefore 1 during and after reset.
  - FIFO storage contents are not reset.
- Reset asserted mid-operation discards all queued and in-flight commands. No response is produced for them.

## Timing

- Push at edge 0 with the FIFO empty and the FSM in IDLE:
  - `interrupt` is high from edge 1 to edge 2, exactly one cycle.
  - `io_inst`/`io_din` are valid from edge 1.
  - `io_dout` is sampled at edge 2+`HOLD`.
  - `rsp_valid` is high from edge 2+`HOLD`.
- Command-to-command issue spacing is at least 2+`HOLD`+1 cycles. This occurs when `rsp_ready` is held high.
- The response handshake completes at the first edge where `rsp_valid & rsp_ready`.
- A command pushed during ISSUE, WAIT or RESP waits in the FIFO. It issues at the edge after the FSM returns to IDLE.

## Configuration

- Macro: `IO_FEEDER_RESP_EN`.
- Defined:
  - Behaviour is as above.
- Undefined:
  - The RESP state and the `rsp_data` register are removed.
  - WAIT goes straight to IDLE when the counter reaches 0.
  - `rsp_valid` is tied to 0 and `rsp_data` is tied to 0.
  - `rsp_ready` is ignored.
  - Issue spacing becomes 2+`HOLD` cycles.

## Test plan

All scenarios use `HOLD`=4 and `DEPTH`=8 unless stated otherwise.

1. **Reset:** hold `reset`=0 for 3 cycles. Outputs are 0 and `cmd_ready`=1. Release; outputs stay 0 with no commands.
2. **Single command:** push inst 0x1234, data 0x5A at edge 0; `io_dout` is driven 0xC3.
   - `interrupt` is high only from edge 1 to edge 2.
   - `io_inst`=0x1234 and `io_din`=0x5A from edge 1.
   - `rsp_valid`=1 with `rsp_data`=0xC3 from edge 6.
3. **Fill FIFO:** push 8 commands back-to-back with `rsp_ready`=0.
   - `cmd_ready` falls after the 8th push, and a 9th attempt is not accepted.
   - After the first issue, `cmd_ready` rises again.
   - Exactly 1 response is pending until `rsp_ready`.
4. **Ordering and wrap-around:** push 20 sequential commands with `rsp_ready`=1 and `io_dout` = f(`io_inst`).
   - 20 responses appear, in order.
   - Pointers wrap twice.
   - Consecutive interrupt pulses are exactly 7 cycles apart.
5. **Reset mid-operation:** assert `reset` during WAIT with 3 commands queued.
   - No `rsp_valid` appears.
   - After release, `cmd_ready`=1 and no `interrupt` occurs until a new push.
6. **Build without `IO_FEEDER_RESP_EN`:** push 2 commands.
   - Interrupts are 6 cycles apart.
   - `rsp_valid` stays 0 throughout.
